// File: rtl/maxnet_controller.sv
// Sequencing FSM for the four-neuron MaxNet winner-take-all datapath.
// Loads the activations, then iterates inhibition updates until one, none, or too many neurons survive.
module maxnet_controller #(
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        nonzero,
  output logic [1:0]        data_sel,
  output logic              reg_ld,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              winner_valid,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
  // done stays high with the result held until the next start or reset.

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t     state;
  state_t     state_nx;
  logic [2:0] pop;
  logic [1:0] first_idx;

  assign pop = {2'b00, nonzero[0]} + {2'b00, nonzero[1]}
             + {2'b00, nonzero[2]} + {2'b00, nonzero[3]};

  // Only meaningful when exactly one bit is set.
  always_comb begin
    first_idx = 2'd0;
    if (nonzero[1]) first_idx = 2'd1;
    if (nonzero[2]) first_idx = 2'd2;
    if (nonzero[3]) first_idx = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    data_sel = 2'b00;
    reg_ld   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        data_sel = 2'b01;
        reg_ld   = 1'b1;
        state_nx = S_EVAL;
      end
      S_EVAL: begin
        if (pop <= 3'd1 || iter_cnt == ITER_LIMIT) state_nx = S_DONE;
        else                                       state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        data_sel = 2'b10;
        reg_ld   = 1'b1;
        state_nx = S_EVAL;
      end
      S_DONE: begin
        if (start) state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_LOAD) || (state == S_EVAL) || (state == S_UPDATE);
  assign done = (state == S_DONE);

  // Results are cleared on entry to LOAD so the flags read zero outside DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      no_winner    <= 1'b0;
      timeout      <= 1'b0;
      iter_cnt     <= '0;
    end else if (state_nx == S_LOAD) begin
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      no_winner    <= 1'b0;
      timeout      <= 1'b0;
      iter_cnt     <= '0;
    end else if (state == S_EVAL && state_nx == S_DONE) begin
      if (pop == 3'd1) begin
        winner       <= first_idx;
        winner_valid <= 1'b1;
      end else if (pop == 3'd0) begin
        no_winner    <= 1'b1;
      end else begin
        timeout      <= 1'b1;
      end
    end else if (state == S_UPDATE) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: a scripted datapath feeds nonzero flags, results are checked
// against a run-level model of the termination rules.
module tb_maxnet_controller;

  localparam int MI = 4;
  localparam int IW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    nonzero;
  logic [1:0]    data_sel;
  logic          reg_ld;
  logic          busy;
  logic          done;
  logic [1:0]    winner;
  logic          winner_valid;
  logic          no_winner;
  logic          timeout;
  logic [IW-1:0] iter_cnt;

  int n_cmp = 0;
  int n_err = 0;

  maxnet_controller #(.MAX_ITER(MI), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .nonzero(nonzero),
    .data_sel(data_sel), .reg_ld(reg_ld), .busy(busy), .done(done),
    .winner(winner), .winner_valid(winner_valid), .no_winner(no_winner),
    .timeout(timeout), .iter_cnt(iter_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scripted datapath ----------------
  // cur_seq nibble j = nonzero flags seen after j updates (last entry repeats).
  logic [31:0] cur_seq;
  int          cur_len;
  int          dp_idx;

  always @(posedge clk or posedge rst) begin
    if (rst)                              dp_idx <= 0;
    else if (reg_ld && data_sel == 2'b01) dp_idx <= 0;
    else if (reg_ld)                      dp_idx <= dp_idx + 1;
  end

  always_comb begin
    int j;
    j = (dp_idx < cur_len) ? dp_idx : cur_len - 1;
    if (j < 0) j = 0;
    nonzero = cur_seq[4*j +: 4];
  end

  // ---------------- vector table / model ----------------
  typedef struct {
    logic [31:0] seq;
    int          len;
    int          win;
    int          wv;
    int          nw;
    int          to;
    int          iter;
    int          dcyc;
  } vec_t;

  function automatic vec_t model(input logic [31:0] seq, input int len);
    vec_t r;
    r.seq = seq; r.len = len;
    r.win = 0; r.wv = 0; r.nw = 0; r.to = 0;
    for (int k = 0; k <= MI; k++) begin
      logic [3:0] v;
      int pc;
      v  = seq[4*((k < len) ? k : len - 1) +: 4];
      pc = $countones(v);
      r.iter = k;
      r.dcyc = 3 + 2*k;
      if (pc == 1) begin
        r.wv = 1;
        for (int b = 0; b < 4; b++) if (v[b]) r.win = b;
        break;
      end
      if (pc == 0) begin r.nw = 1; break; end
      if (k == MI) begin r.to = 1; break; end
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge inside cycle 1 (the LOAD cycle).
  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int poke);
    int c, rl, s10, bc, got, bad;
    cur_seq = v.seq; cur_len = v.len;
    start_run();
    c = 1; rl = 0; s10 = 0; bc = 0; got = 0; bad = 0;
    while (c <= 200) begin
      if (reg_ld) rl++;
      if (data_sel == 2'b10) s10++;
      if (busy) bc++;
      if (data_sel == 2'b11) bad = 1;
      if (!done && (winner_valid || no_winner || timeout)) bad = 1;
      start = (c == poke);
      if (done) begin got = 1; break; end
      @(negedge clk); c++;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("done_cycle", c, v.dcyc);
    check("winner", int'(winner), v.win);
    check("winner_valid", int'(winner_valid), v.wv);
    check("no_winner", int'(no_winner), v.nw);
    check("timeout", int'(timeout), v.to);
    check("iter_cnt", int'(iter_cnt), v.iter);
    check("reg_ld_cycles", rl, 1 + v.iter);
    check("update_cycles", s10, v.iter);
    check("busy_cycles", bc, 2 + 2*v.iter);
    check("flags_outside_done", bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_sel"}, int'(data_sel), 0);
    check({tag, "_reg_ld"}, int'(reg_ld), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_flags"}, int'({winner, winner_valid, no_winner, timeout}), 0);
    check({tag, "_iter_cnt"}, int'(iter_cnt), 0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'h0000_1FFF, 4, 0, 1, 0, 0, 3, 9};
    tbl[1] = '{32'h0000_0004, 1, 2, 1, 0, 0, 0, 3};
    tbl[2] = '{32'h0000_0033, 3, 0, 0, 1, 0, 2, 7};
    tbl[3] = '{32'h0000_0003, 1, 0, 0, 0, 1, 4, 11};
    tbl[4] = '{32'h0000_0000, 1, 0, 0, 1, 0, 0, 3};
    tbl[5] = '{32'h0000_008A, 2, 3, 1, 0, 0, 1, 5};

    start = 1'b0; cur_seq = 32'hF; cur_len = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    for (int i = 0; i < 6; i++) run_case(tbl[i], 0);

    // start during UPDATE (cycle 3) is ignored
    run_case(tbl[3], 3);

    // restart from DONE: LOAD next cycle with flags cleared
    run_case(tbl[1], 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_busy", int'(busy), 1);
    check("restart_done", int'(done), 0);
    check("restart_sel", int'(data_sel), 1);
    check("restart_reg_ld", int'(reg_ld), 1);
    check("restart_flags", int'({winner, winner_valid, no_winner, timeout}), 0);
    check("restart_iter", int'(iter_cnt), 0);
    repeat (2) @(negedge clk);
    check("restart_done_again", int'(done), 1);
    check("restart_winner", int'(winner), 2);

    // asynchronous reset in the second UPDATE cycle
    cur_seq = 32'h3; cur_len = 1;
    start_run();
    repeat (4) @(negedge clk);
    check("pre_reset_sel", int'(data_sel), 2);
    check("pre_reset_iter", int'(iter_cnt), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk); rst = 1'b0;
    run_case(tbl[0], 0);

    // randomized runs against the model
    for (int r = 0; r < 40; r++) begin
      logic [31:0] s;
      int l;
      s = $urandom;
      l = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) s[4*(l-1) +: 4] = 4'b0001 << $urandom_range(0, 3);
      run_case(model(s, l), ($urandom_range(0, 2) == 0) ? 3 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing FSM for the MaxNet winner-take-all datapath. It drives the shared select of the per-neuron `four_to_one_mux_parametrized` input muxes and the neuron-register load enable. It first loads the initial activations, then iterates the inhibition update until exactly one neuron stays nonzero, none do, or an iteration limit is hit. It sits between the top-level start/result interface and the four-neuron datapath.

## Interface
Parameters:
- `MAX_ITER`, 15: maximum number of update iterations before timeout (1..255).
- `ITER_W`, 8: width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  single-cycle request to run; sampled only in IDLE and DONE.
- `nonzero`  in  4  per-neuron flag from datapath: bit i = neuron register i > 0 (combinational from registers).
- `data_sel`  out  2  mux select to datapath: 00 hold, 01 load external inputs, 10 load update result, 11 reserved (never driven).
- `reg_ld`  out  1  neuron-register load enable.
- `busy`  out  1  high in LOAD, EVAL, UPDATE.
- `done`  out  1  high while in DONE.
- `winner`  out  2  index of surviving neuron; valid when `winner_valid`.
- `winner_valid`  out  1  exactly one neuron survived.
- `no_winner`  out  1  all neurons reached zero (tie).
- `timeout`  out  1  MAX_ITER updates done with ≥2 survivors.
- `iter_cnt`  out  ITER_W  number of UPDATE cycles executed in current run.

## Operation
- States: IDLE, LOAD, EVAL, UPDATE, DONE; Moore outputs, registered state.
- IDLE: data_sel=00, reg_ld=0. start=1 → LOAD.
- LOAD: data_sel=01, reg_ld=1; clear iter_cnt, winner, winner_valid, no_winner, timeout → EVAL.
- EVAL: data_sel=00, reg_ld=0; decide from popcount(nonzero), priority in order:
  - popcount==1 → DONE; latch winner = index of set bit, winner_valid=1.
  - popcount==0 → DONE; no_winner=1, winner=0.
  - iter_cnt==MAX_ITER → DONE; timeout=1.
  - else → UPDATE.
- UPDATE: data_sel=10, reg_ld=1, iter_cnt += 1 → EVAL.
- DONE: data_sel=00, reg_ld=0; result flags and winner held. start=1 → LOAD (restart); otherwise stay.
- start in LOAD/EVAL/UPDATE is ignored (no queuing).
- Exactly one of winner_valid/no_winner/timeout is high in DONE; all are 0 outside DONE.
- iter_cnt never wraps; it saturates at MAX_ITER because EVAL exits first.

## Timing
- Reset (async): state=IDLE, data_sel=00, reg_ld=0, busy=0, done=0, winner=0, winner_valid=0, no_winner=0, timeout=0, iter_cnt=0. Deassertion is used synchronously at the next edge.
- With start sampled high at edge 0: LOAD during cycle 1, EVAL during cycle 2, each UPDATE+EVAL pair adds 2 cycles.
- done rises at cycle 3 + 2k after k updates; worst case is 3 + 2·MAX_ITER.
- reg_ld is high exactly in LOAD and UPDATE cycles; data_sel changes only on state changes.
- nonzero must settle within the EVAL cycle (registers updated at the LOAD/UPDATE edge).
- Reset mid-run: immediate return to IDLE, all outputs to reset values, run discarded.

## Test plan
- Inputs 9,3,2,1 (nonzero=1111, then the datapath converges so only bit 0 is set after 3 updates) → done at cycle 9, winner=0, winner_valid=1, iter_cnt=3.
- Only neuron 2 nonzero at load (nonzero=0100) → done at cycle 3, winner=2, iter_cnt=0, reg_ld pulsed once.
- Tie 5,5,0,0 with the datapath driving both to zero after 2 updates (nonzero 0011→0011→0000) → no_winner=1, winner_valid=0, done at cycle 7.
- MAX_ITER=4, nonzero stuck at 0011 → timeout=1 at cycle 11, iter_cnt=4, exactly 4 cycles with data_sel=10.
- start pulsed during UPDATE → ignored; start in DONE → LOAD next cycle with flags cleared and iter_cnt=0.
- rst asserted asynchronously mid-UPDATE → outputs zero immediately without a clock edge; next start runs normally.
